// File: rtl/coherence_bus_pkg.sv
// Shared types and default widths for the snooping CommonBus arbiter.
package coherence_bus_pkg;

   localparam int unsigned BUS_ADDR_W = 16;
   localparam int unsigned BUS_DATA_W = 32;

   typedef enum logic {
      CMD_RD  = 1'b0,
      CMD_UPD = 1'b1
   } bus_cmd_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      SNOOP = 3'd2,
      DATA  = 3'd3,
      DONE  = 3'd4
   } arb_state_e;

endpackage

// File: rtl/snoop_bus_arbiter_picker.sv
// Round-robin priority picker: one-hot winner is the first set request at/after ptr, cyclic.
module rr_priority_picker #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         winner
);

   localparam int unsigned IDX_W = $clog2(N);

   always_comb begin
      logic        found;
      int unsigned idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = (32'(ptr) + off) % N;
         if (!found && req[IDX_W'(idx)]) begin
            winner[IDX_W'(idx)] = 1'b1;
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared snooping CommonBus (ADDR -> SNOOP -> DATA -> DONE).
// Optional per-cache grant counters on perf_grants when SNOOP_ARB_PERF_EN is defined.
module snoop_bus_arbiter
   import coherence_bus_pkg::*;
#(
   parameter int unsigned NUM_CACHES   = 4,
   parameter int unsigned ADDRESSWIDTH = BUS_ADDR_W,
   parameter int unsigned DATABUSWIDTH = BUS_DATA_W,
   parameter int unsigned SNOOP_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_CACHES-1:0]              req_valid,
   input  logic [NUM_CACHES-1:0]              req_upd,
   input  logic [NUM_CACHES*ADDRESSWIDTH-1:0] req_addr,
   input  logic [NUM_CACHES*DATABUSWIDTH-1:0] req_data,
   output logic [NUM_CACHES-1:0]              grant,
   output logic [NUM_CACHES-1:0]              req_ack,
   output logic                               req_err,
   output logic [DATABUSWIDTH-1:0]            rsp_data,
   output logic                               bus_rd,
   output logic                               bus_upd,
   output logic [ADDRESSWIDTH-1:0]            bus_addr,
   output logic [DATABUSWIDTH-1:0]            bus_data,
   input  logic [NUM_CACHES-1:0]              snoop_shared,
   output logic                               bus_shared,
   input  logic                               fill_valid,
   input  logic [DATABUSWIDTH-1:0]            fill_data
`ifdef SNOOP_ARB_PERF_EN
   ,
   output logic [NUM_CACHES*16-1:0]           perf_grants
`endif
);

   localparam int unsigned IDX_W   = $clog2(NUM_CACHES);
   localparam int unsigned CNT_MAX = (TIMEOUT > SNOOP_CYCLES) ? TIMEOUT : SNOOP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   arb_state_e               state_q, state_d;
   bus_cmd_e                 cmd_q, cmd_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NUM_CACHES-1:0]    grant_q, grant_d;
   logic [NUM_CACHES-1:0]    ack_q, ack_d;
   logic                     err_q, err_d;
   logic [DATABUSWIDTH-1:0]  rsp_q, rsp_d;
   logic                     rd_q, rd_d;
   logic                     upd_q, upd_d;
   logic [ADDRESSWIDTH-1:0]  addr_q, addr_d;
   logic [DATABUSWIDTH-1:0]  data_q, data_d;
   logic                     shared_q, shared_d;

   logic [NUM_CACHES-1:0]    win;
   logic                     sel_upd;
   logic [ADDRESSWIDTH-1:0]  sel_addr;
   logic [DATABUSWIDTH-1:0]  sel_data;
   logic [IDX_W-1:0]         owner_idx;

   rr_priority_picker #(.N(NUM_CACHES)) u_picker (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .winner (win)
   );

   // Request mux for the arbitration winner and index of the current owner.
   always_comb begin
      sel_upd   = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      owner_idx = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         if (win[i]) begin
            sel_upd  = req_upd[i];
            sel_addr = req_addr[i*ADDRESSWIDTH +: ADDRESSWIDTH];
            sel_data = req_data[i*DATABUSWIDTH +: DATABUSWIDTH];
         end
         if (grant_q[i]) begin
            owner_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      ack_d    = '0;
      err_d    = 1'b0;
      rsp_d    = rsp_q;
      rd_d     = 1'b0;
      upd_d    = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      shared_d = shared_q;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d  = ADDR;
               grant_d  = win;
               cmd_d    = sel_upd ? CMD_UPD : CMD_RD;
               rd_d     = ~sel_upd;
               upd_d    = sel_upd;
               addr_d   = sel_addr;
               data_d   = sel_upd ? sel_data : '0;
               shared_d = 1'b0;
               rsp_d    = '0;
               cnt_d    = '0;
            end
         end
         ADDR: begin
            state_d = SNOOP;
            cnt_d   = '0;
         end
         SNOOP: begin
            // Owner's own Shared line never counts toward the wired-OR.
            shared_d = shared_q | (|(snoop_shared & ~grant_q));
            if (cnt_q == CNT_W'(SNOOP_CYCLES - 1)) begin
               cnt_d = '0;
               if (cmd_q == CMD_UPD) begin
                  state_d = DONE;
                  ack_d   = grant_q;
               end else begin
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (fill_valid) begin
               state_d = DONE;
               rsp_d   = fill_data;
               ack_d   = grant_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = DONE;
               rsp_d   = '0;
               err_d   = 1'b1;
               ack_d   = grant_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d  = IDLE;
            grant_d  = '0;
            addr_d   = '0;
            data_d   = '0;
            shared_d = 1'b0;
            rsp_d    = '0;
            cnt_d    = '0;
            rr_ptr_d = (owner_idx == IDX_W'(NUM_CACHES - 1)) ? '0 : owner_idx + IDX_W'(1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cmd_q    <= CMD_RD;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         rsp_q    <= '0;
         rd_q     <= 1'b0;
         upd_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         shared_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rsp_q    <= rsp_d;
         rd_q     <= rd_d;
         upd_q    <= upd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         shared_q <= shared_d;
      end
   end

   assign grant      = grant_q;
   assign req_ack    = ack_q;
   assign req_err    = err_q;
   assign rsp_data   = rsp_q;
   assign bus_rd     = rd_q;
   assign bus_upd    = upd_q;
   assign bus_addr   = addr_q;
   assign bus_data   = data_q;
   assign bus_shared = shared_q;

`ifdef SNOOP_ARB_PERF_EN
   logic [NUM_CACHES-1:0][15:0] perf_q, perf_d;

   // Saturating per-cache grant counters, bumped once per completed transaction.
   always_comb begin
      perf_d = perf_q;
      if (state_q == DONE) begin
         for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            if (grant_q[i] && (perf_q[i] != 16'hFFFF)) begin
               perf_d[i] = perf_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_grants = perf_q;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter (default parameters).
module tb_snoop_bus_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic            clock;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_upd;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant;
   logic [N-1:0]    req_ack;
   logic            req_err;
   logic [DW-1:0]   rsp_data;
   logic            bus_rd;
   logic            bus_upd;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_data;
   logic [N-1:0]    snoop_shared;
   logic            bus_shared;
   logic            fill_valid;
   logic [DW-1:0]   fill_data;
`ifdef SNOOP_ARB_PERF_EN
   logic [N*16-1:0] perf_grants;
`endif

   int n_checks = 0;
   int n_errors = 0;

   snoop_bus_arbiter dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_upd      (req_upd),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .grant        (grant),
      .req_ack      (req_ack),
      .req_err      (req_err),
      .rsp_data     (rsp_data),
      .bus_rd       (bus_rd),
      .bus_upd      (bus_upd),
      .bus_addr     (bus_addr),
      .bus_data     (bus_data),
      .snoop_shared (snoop_shared),
      .bus_shared   (bus_shared),
      .fill_valid   (fill_valid),
      .fill_data    (fill_data)
`ifdef SNOOP_ARB_PERF_EN
      ,
      .perf_grants  (perf_grants)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic upd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]        = 1'b1;
      req_upd[i]          = upd;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      int o;
      reset        = 1'b1;
      req_valid    = '0;
      req_upd      = '0;
      req_addr     = '0;
      req_data     = '0;
      snoop_shared = '0;
      fill_valid   = 1'b0;
      fill_data    = '0;
      tick(2);
      check_eq("rst_grant", 64'(grant), 64'h0);
      check_eq("rst_ack", 64'(req_ack), 64'h0);
      check_eq("rst_addr", 64'(bus_addr), 64'h0);
      check_eq("rst_shared", 64'(bus_shared), 64'h0);
      check_eq("rst_rsp", 64'(rsp_data), 64'h0);
      reset = 1'b0;

      // Cache1 BusUpd
      set_req(1, 1'b1, 16'h0504, 32'hABCDEF12);
      tick(1);
      check_eq("upd_grant", 64'(grant), 64'h2);
      check_eq("upd_cmd", 64'(bus_upd), 64'h1);
      check_eq("upd_rd", 64'(bus_rd), 64'h0);
      check_eq("upd_addr", 64'(bus_addr), 64'h0504);
      check_eq("upd_data", 64'(bus_data), 64'hABCDEF12);
      tick(1);
      check_eq("upd_cmd_drop", 64'(bus_upd), 64'h0);
      check_eq("upd_addr_hold", 64'(bus_addr), 64'h0504);
      tick(1);
      check_eq("upd_no_ack_t3", 64'(req_ack), 64'h0);
      tick(1);
      check_eq("upd_ack_t4", 64'(req_ack), 64'h2);
      check_eq("upd_err", 64'(req_err), 64'h0);
      req_valid[1] = 1'b0;
      tick(1);
      check_eq("upd_idle_grant", 64'(grant), 64'h0);
      check_eq("upd_idle_addr", 64'(bus_addr), 64'h0);
      check_eq("upd_idle_data", 64'(bus_data), 64'h0);
      check_eq("upd_ack_pulse", 64'(req_ack), 64'h0);

      // Cache0 BusRd, cache2 shares, stray fill in SNOOP, real fill at k=2
      set_req(0, 1'b0, 16'h0400, 32'h0);
      tick(1);
      check_eq("rd_grant", 64'(grant), 64'h1);
      check_eq("rd_cmd", 64'(bus_rd), 64'h1);
      check_eq("rd_bus_data", 64'(bus_data), 64'h0);
      tick(1);
      check_eq("rd_cmd_drop", 64'(bus_rd), 64'h0);
      snoop_shared = 4'b0100;
      tick(1);
      snoop_shared = '0;
      check_eq("rd_shared_early", 64'(bus_shared), 64'h1);
      fill_valid = 1'b1;
      fill_data  = 32'hDEADBEEF;
      tick(1);
      fill_valid = 1'b0;
      tick(1);
      check_eq("rd_no_ack_k1", 64'(req_ack), 64'h0);
      tick(1);
      fill_valid = 1'b1;
      fill_data  = 32'h12345678;
      tick(1);
      fill_valid = 1'b0;
      check_eq("rd_ack", 64'(req_ack), 64'h1);
      check_eq("rd_rsp", 64'(rsp_data), 64'h12345678);
      check_eq("rd_shared", 64'(bus_shared), 64'h1);
      check_eq("rd_err", 64'(req_err), 64'h0);
      req_valid[0] = 1'b0;
      tick(1);
      check_eq("rd_idle_shared", 64'(bus_shared), 64'h0);
      check_eq("rd_idle_rsp", 64'(rsp_data), 64'h0);

      // Reset in the middle of a SNOOP window
      set_req(3, 1'b0, 16'h0777, 32'h0);
      tick(1);
      check_eq("mid_grant", 64'(grant), 64'h8);
      tick(1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_grant", 64'(grant), 64'h0);
      check_eq("mid_rst_addr", 64'(bus_addr), 64'h0);
      check_eq("mid_rst_rd", 64'(bus_rd), 64'h0);
      check_eq("mid_rst_ack", 64'(req_ack), 64'h0);
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(16'h1000 + i), DW'(32'hA0 + i));

      // All four request: grants 0,1,2,3 then wrap to 0
      for (int k = 0; k < 5; k++) begin
         o = k % 4;
         tick(1);
         check_eq($sformatf("rr_grant_%0d", k), 64'(grant), 64'(1 << o));
         check_eq($sformatf("rr_addr_%0d", k), 64'(bus_addr), 64'(16'h1000 + o));
         tick(3);
         check_eq($sformatf("rr_ack_%0d", k), 64'(req_ack), 64'(1 << o));
         if (k == 4) req_valid = '0;
         tick(1);
      end

      // Cache2 BusRd: own Shared only, drops request mid-flight, never filled
      set_req(2, 1'b0, 16'h0900, 32'h0);
      tick(1);
      check_eq("to_grant", 64'(grant), 64'h4);
      tick(1);
      snoop_shared = 4'b0100;
      req_valid[2] = 1'b0;
      tick(2);
      snoop_shared = '0;
      tick(63);
      check_eq("to_no_ack_t67", 64'(req_ack), 64'h0);
      tick(1);
      check_eq("to_ack", 64'(req_ack), 64'h4);
      check_eq("to_err", 64'(req_err), 64'h1);
      check_eq("to_rsp", 64'(rsp_data), 64'h0);
      check_eq("to_own_shared", 64'(bus_shared), 64'h0);
      tick(1);
      check_eq("to_err_pulse", 64'(req_err), 64'h0);
      check_eq("to_idle_grant", 64'(grant), 64'h0);

`ifdef SNOOP_ARB_PERF_EN
      check_eq("perf_0", 64'(perf_grants[0*16 +: 16]), 64'd2);
      check_eq("perf_1", 64'(perf_grants[1*16 +: 16]), 64'd1);
      check_eq("perf_2", 64'(perf_grants[2*16 +: 16]), 64'd2);
      check_eq("perf_3", 64'(perf_grants[3*16 +: 16]), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
